// File: rtl/ra_port_arb_sdr.sv
// ra_port_arb_sdr: shares one 2-read/1-write SDR array between N requesters.
// Each cycle grants up to one write (write port 0) and two reads (read
// ports 0/1) using independent round-robin pointers. Read data is routed
// back to the owning requester after the array read latency.
module ra_port_arb_sdr #(
  parameter int N      = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [N-1:0]      req_vld,
  input  logic [N-1:0]      req_wr,
  input  logic [6*N-1:0]    req_adr,
  input  logic [72*N-1:0]   req_dat,
  output logic [N-1:0]      req_gnt,
  output logic [N-1:0]      rsp_vld,
  output logic [72*N-1:0]   rsp_dat,
  output logic              rd_enb_0,
  output logic [5:0]        rd_adr_0,
  input  logic [71:0]       rd_dat_0,
  output logic              rd_enb_1,
  output logic [5:0]        rd_adr_1,
  input  logic [71:0]       rd_dat_1,
  output logic              wr_enb_0,
  output logic [5:0]        wr_adr_0,
  output logic [71:0]       wr_dat_0
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  // (base + k) mod N, with k < N so a single subtraction is enough
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          wr_found;
  logic [PW-1:0] wr_win;
  logic [5:0]    wr_adr_sel;
  logic          write_go;

  logic [N-1:0]  cand;
  logic          got_0, got_1;
  logic [PW-1:0] win_0, win_1;
  logic          rd_go_0, rd_go_1;

  logic [RD_LAT-1:0] sv_0, sv_1;
  logic [PW-1:0]     sid_0 [RD_LAT];
  logic [PW-1:0]     sid_1 [RD_LAT];

  // Write winner: first writing requester at or after wr_ptr
  always_comb begin
    wr_found = 1'b0;
    wr_win   = '0;
    for (int k = 0; k < N; k++) begin
      if (!wr_found && req_vld[wrap(wr_ptr, k)] && req_wr[wrap(wr_ptr, k)]) begin
        wr_found = 1'b1;
        wr_win   = wrap(wr_ptr, k);
      end
    end
  end

  assign wr_adr_sel = req_adr[6*int'(wr_win) +: 6];
  assign write_go   = wr_found & ~hold;

  // Read candidates; a read hitting the address being written this cycle waits
  always_comb begin
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand[i] = req_vld[i] & ~req_wr[i] &
                ~(write_go && (req_adr[6*i +: 6] == wr_adr_sel));
    end
  end

  // Read winners: first two candidates at or after rd_ptr
  always_comb begin
    got_0 = 1'b0;
    got_1 = 1'b0;
    win_0 = '0;
    win_1 = '0;
    for (int k = 0; k < N; k++) begin
      if (cand[wrap(rd_ptr, k)]) begin
        if (!got_0) begin
          got_0 = 1'b1;
          win_0 = wrap(rd_ptr, k);
        end else if (!got_1) begin
          got_1 = 1'b1;
          win_1 = wrap(rd_ptr, k);
        end
      end
    end
  end

  assign rd_go_0 = got_0 & ~hold;
  assign rd_go_1 = got_1 & ~hold;

  // Grants and array commands, all zero when nothing wins or hold is set
  always_comb begin
    req_gnt = '0;
    if (write_go) req_gnt[wr_win] = 1'b1;
    if (rd_go_0)  req_gnt[win_0]  = 1'b1;
    if (rd_go_1)  req_gnt[win_1]  = 1'b1;
  end

  assign wr_enb_0 = write_go;
  assign wr_adr_0 = write_go ? wr_adr_sel : 6'd0;
  assign wr_dat_0 = write_go ? req_dat[72*int'(wr_win) +: 72] : 72'd0;
  assign rd_enb_0 = rd_go_0;
  assign rd_adr_0 = rd_go_0 ? req_adr[6*int'(win_0) +: 6] : 6'd0;
  assign rd_enb_1 = rd_go_1;
  assign rd_adr_1 = rd_go_1 ? req_adr[6*int'(win_1) +: 6] : 6'd0;

  // Round-robin pointers advance past the last winner of each kind
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (write_go) wr_ptr <= wrap(wr_win, 1);
      if (rd_go_1)      rd_ptr <= wrap(win_1, 1);
      else if (rd_go_0) rd_ptr <= wrap(win_0, 1);
    end
  end

  // Per-port {valid, id} pipelines matching the array read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sv_0 <= '0;
      sv_1 <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        sid_0[i] <= '0;
        sid_1[i] <= '0;
      end
    end else begin
      sv_0[0]  <= rd_go_0;
      sv_1[0]  <= rd_go_1;
      sid_0[0] <= win_0;
      sid_1[0] <= win_1;
      for (int i = 1; i < RD_LAT; i++) begin
        sv_0[i]  <= sv_0[i-1];
        sv_1[i]  <= sv_1[i-1];
        sid_0[i] <= sid_0[i-1];
        sid_1[i] <= sid_1[i-1];
      end
    end
  end

  // Steer array read data to the owning requester; zero when not valid
  always_comb begin
    rsp_vld = '0;
    rsp_dat = '0;
    if (sv_0[RD_LAT-1]) begin
      rsp_vld[sid_0[RD_LAT-1]] = 1'b1;
      rsp_dat[72*int'(sid_0[RD_LAT-1]) +: 72] = rd_dat_0;
    end
    if (sv_1[RD_LAT-1]) begin
      rsp_vld[sid_1[RD_LAT-1]] = 1'b1;
      rsp_dat[72*int'(sid_1[RD_LAT-1]) +: 72] = rd_dat_1;
    end
  end

endmodule
